// File: rtl/adder_seq_arbiter.sv
// adder_seq_arbiter
// -----------------
// Nibble-serial add/subtract engine. Two requesters share one 4-bit
// ripple-carry adder slice. A round-robin arbiter picks a requester. Its
// operands are captured, then the slice processes them one nibble per cycle,
// least-significant nibble first. The carry is held in a register between
// nibble steps.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/ready/a/b/sub   requester 0 operation (sub=1 -> A-B)
//   req1_valid/ready/a/b/sub   requester 1 operation
//   res_valid/ready            result handshake (registered valid)
//   res_sum, res_cout, res_id  result word, final carry, issuing requester
//   o_dbg_state                current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake semantics (all three ports): a transfer happens on a rising
// edge where valid and ready are both 1. reqN_ready is only ever asserted
// alongside reqN_valid, and only in IDLE. res_valid stays high with the
// result held stable until the consumer takes it with res_ready.

module adder_seq_arbiter #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic [1:0]   o_dbg_state
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_prio;
  logic [KW-1:0]  r_k;
  logic           r_carry;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sub;
  logic           r_res_valid;
  logic [W-1:0]   r_res_sum;
  logic           r_res_cout;
  logic           r_res_id;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic           w_acc_id;
  logic           w_last;
  logic [3:0]     w_x;
  logic [3:0]     w_b_nib;
  logic [3:0]     w_y;
  logic           w_cin;
  logic [3:0]     w_s;
  logic [4:0]     w_c;
  logic           w_cout;

  // Arbitration: a lone valid requester wins; on a tie the priority
  // pointer decides. rst_n gates ready so nothing is accepted in reset.
  assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
  assign w_grant1   = req1_valid & (~req0_valid |  r_prio);
  assign req0_ready = (r_state == S_IDLE) & w_grant0 & rst_n;
  assign req1_ready = (r_state == S_IDLE) & w_grant1 & rst_n;
  assign w_accept   = req0_ready | req1_ready;
  assign w_acc_id   = req1_ready;

  assign w_last = (r_k == KW'(NIBBLES - 1));

  // Select the current nibble of the captured operands.
  always_comb begin
    w_x     = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_k == KW'(i)) begin
        w_x     = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
  end

  // Subtraction is A + ~B + 1; the +1 is the carry register preloaded with sub.
  assign w_y   = r_sub ? ~w_b_nib : w_b_nib;
  assign w_cin = r_carry;

  // Shared 4-bit ripple-carry slice.
  always_comb begin
    w_c    = '0;
    w_s    = '0;
    w_c[0] = w_cin;
    for (int i = 0; i < 4; i++) begin
      w_s[i]   = w_x[i] ^ w_y[i] ^ w_c[i];
      w_c[i+1] = (w_x[i] & w_y[i]) | (w_x[i] & w_c[i]) | (w_y[i] & w_c[i]);
    end
  end
  assign w_cout = w_c[4];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, nibble stepping, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= 1'b0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= w_acc_id ? req1_a   : req0_a;
            r_b      <= w_acc_id ? req1_b   : req0_b;
            r_sub    <= w_acc_id ? req1_sub : req0_sub;
            r_carry  <= w_acc_id ? req1_sub : req0_sub;
            r_res_id <= w_acc_id;
            r_k      <= '0;
            // The requester just served drops to lowest priority.
            r_prio   <= ~w_acc_id;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_k == KW'(i)) r_res_sum[4*i +: 4] <= w_s;
          end
          r_carry <= w_cout;
          if (w_last) begin
            r_k         <= '0;
            r_res_cout  <= w_cout;
            r_res_valid <= 1'b1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign res_valid   = r_res_valid;
  assign res_sum     = r_res_sum;
  assign res_cout    = r_res_cout;
  assign res_id      = r_res_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Testbench for adder_seq_arbiter (NIBBLES = 4, W = 16).
module tb_adder_seq_arbiter;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int NV      = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id;
  logic [W-1:0] res_sum;
  logic [1:0]   dbg_state;

  adder_seq_arbiter #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full-width arithmetic, returns {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];    // {id, cout, sum}
  int           acc_id_q[$];
  int           acc_cyc_q[$];
  logic         prev_rv = 1'b0;
  int           last_acc_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready) check("ready0_needs_valid", 32'(req0_valid), 32'd1);
      if (req1_ready) check("ready1_needs_valid", 32'(req1_valid), 32'd1);
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, model(req0_a, req0_b, req0_sub)});
        acc_id_q.push_back(0);
        acc_cyc_q.push_back(cyc);
        last_acc_cyc <= cyc;
      end else if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, model(req1_a, req1_b, req1_sub)});
        acc_id_q.push_back(1);
        acc_cyc_q.push_back(cyc);
        last_acc_cyc <= cyc;
      end
      if (res_valid && !prev_rv)
        check("latency", 32'(cyc - last_acc_cyc), 32'(NIBBLES + 1));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("sb_result", 32'({res_id, res_cout, res_sum}), 32'(e));
        end
      end
      prev_rv <= res_valid;
    end else begin
      prev_rv <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents an operation and waits for its accept; returns just after the
  // accepting edge. hold=1 leaves valid asserted for back-to-back issue.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input bit hold);
    bit ok;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    check($sformatf("accept_req%0d", id), 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (!hold) begin
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] sum,
                             input logic cout, input int id);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_sum"},  32'(res_sum),  32'(sum));
    check({name, "_cout"}, 32'(res_cout), 32'(cout));
    check({name, "_id"},   32'(res_id),   32'(id));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && !res_valid && (dbg_state == 2'd0);
    end
    check("drain", 32'(idle), 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;
  vec_t vecs[NV];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
    vecs[3] = '{1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
    vecs[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7] = '{1, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1};

    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    res_ready = 1'b1;
    // Valid held high during reset: ready must stay low regardless.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    check("rst_res_valid", 32'(res_valid),  32'd0);
    check("rst_res_sum",   32'(res_sum),    32'd0);
    check("rst_res_cout",  32'(res_cout),   32'd0);
    check("rst_res_id",    32'(res_id),     32'd0);
    check("rst_ready0",    32'(req0_ready), 32'd0);
    check("rst_ready1",    32'(req1_ready), 32'd0);
    check("rst_state",     32'(dbg_state),  32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single operations.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
      wait_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].id);
    end
    drain();

    // Carry ripple: adder Cin per RUN cycle is 0,1,1,1.
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int n = 0; n < NIBBLES; n++) begin
      @(negedge clk);
      check($sformatf("cin_nib%0d", n), 32'(dut.w_cin), (n == 0) ? 32'd0 : 32'd1);
    end
    drain();

    // Both requesters valid from reset exit: grants alternate 0,1,0,1.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    acc_id_q.delete(); acc_cyc_q.delete();
    rst_n = 1'b1;
    fork
      begin
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b1);
        issue(0, 16'h9000, 16'h0001, 1'b1, 1'b0);
      end
      begin
        issue(1, 16'h4321, 16'h1234, 1'b1, 1'b1);
        issue(1, 16'hF0F0, 16'h0F10, 1'b0, 1'b0);
      end
    join
    drain();
    check("alt_count", 32'(acc_id_q.size()), 32'd4);
    if (acc_id_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("alt_grant%0d", i), 32'(acc_id_q[i]), 32'(i % 2));
        if (i > 0)
          check($sformatf("alt_spacing%0d", i), 32'(acc_cyc_q[i] - acc_cyc_q[i-1]),
                32'(NIBBLES + 2));
      end
    end

    // Backpressure: result held 10 cycles, req1 waits.
    res_ready = 1'b0;
    issue(0, 16'h00F0, 16'h0F0F, 1'b0, 1'b0);
    req1_a = 16'h3000; req1_b = 16'h1000; req1_sub = 1'b1; req1_valid = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = res_valid;
      end
      check("bp_seen", 32'(seen), 32'd1);
    end
    for (int j = 0; j < 10; j++) begin
      check("bp_valid", 32'(res_valid),  32'd1);
      check("bp_sum",   32'(res_sum),    32'h0FFF);
      check("bp_cout",  32'(res_cout),   32'd0);
      check("bp_id",    32'(res_id),     32'd0);
      check("bp_ready1",32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_state", 32'(dbg_state),  32'd0);
    check("bp_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0; res_ready = 1'b1;
    drain();

    // Reset during RUN aborts the operation; req0 wins after release.
    req1_a = 16'h0101; req1_b = 16'h0202; req1_sub = 1'b0; req1_valid = 1'b1;
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_res_valid", 32'(res_valid),  32'd0);
    check("abort_ready0",    32'(req0_ready), 32'd0);
    check("abort_ready1",    32'(req1_ready), 32'd0);
    check("abort_state",     32'(dbg_state),  32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready0",    32'(req0_ready), 32'd1);
    check("post_rst_ready1",    32'(req1_ready), 32'd0);
    check("post_rst_res_valid", 32'(res_valid),  32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    issue(1, 16'h0101, 16'h0202, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
